conv2x2_window_feeder: RTL and testbench
========================================

# conv2x2_window_feeder

Raster-stream to 2x2 window generator that sits directly upstream of the 2x2 convolution stage. It accepts one 8-bit pixel per cycle in raster order and keeps the previous image row in an internal line buffer. It emits every overlapping 2x2 window of the frame as a 32-bit packed word, using the byte order the convolution stage expects. Valid/ready handshakes are used on both sides, so back-pressure from the convolution stage stalls the pixel source losslessly.

## Interface
- IMG_W, 8, image width in pixels (legal 2..64)
- IMG_H, 8, image height in pixels (legal 2..64)

- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  pixel source has a pixel on in_pixel
- in_ready  output  1  block accepts a pixel this cycle
- in_pixel  input  8  unsigned pixel value
- in_sof  input  1  qualifies the accepted pixel as frame start (x=0, y=0)
- win_valid  output  1  win_data holds a window
- win_ready  input  1  downstream consumes the window this cycle
- win_data  output  32  [7:0]=top-left, [15:8]=top-right, [23:16]=bottom-left, [31:24]=bottom-right
- win_last  output  1  window is the last one of the frame
- win_x  output  6  column of the bottom-right pixel of the window (1..IMG_W-1)
- win_y  output  6  row of the bottom-right pixel of the window (1..IMG_H-1)
- sof_err  output  1  one-cycle pulse: in_sof accepted while position counter was not (0,0)

## Operation
- Accept: a pixel is taken when in_valid && in_ready. The pixel's position (x,y) is the current value of the counters.
- Counters:
  - x increments on every accept. At IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), both x and y wrap to 0.
  - An accept with in_sof=1 treats that pixel as (0,0), so the counters become (1,0) or (0,1) if IMG_W would wrap; IMG_W≥2 means x becomes 1.
  - If the counters were not (0,0) at that accept, sof_err pulses on the next cycle.
- Line buffer:
  - IMG_W×8-bit storage. Entry x holds the pixel at column x of the previous row.
  - On an accept at x, entry x is read (top-right, TR) and then overwritten with the new pixel.
  - Registers tl_q (the previous TR) and bl_q (the previous accepted pixel) supply top-left and bottom-left.
- Window emit:
  - On an accept with x≥1 and y≥1, load win_data={pixel, bl_q, TR, tl_q}, win_x=x, win_y=y, win_last=(x==IMG_W-1 && y==IMG_H-1), and set win_valid.
  - Accepts in row 0 or at column 0 update the line buffer, tl_q and bl_q only.
- Windows per frame: (IMG_W-1)*(IMG_H-1), strictly in raster order of the bottom-right pixel.
- Output register: single-entry. win_valid clears on win_ready unless a new window loads in the same cycle.
- Line buffer contents are not reset. Row 0 never emits, so stale contents are never observable.
- Reset (rst_n=0 at a clock edge), including mid-frame:
  - win_valid=0, win_data=0, win_last=0, win_x=0, win_y=0, sof_err=0; counters go to (0,0), tl_q=0, bl_q=0.
  - Any held window is discarded. The next accepted pixel is (0,0) regardless of in_sof.

## Timing
- in_ready = !win_valid || win_ready (combinational). in_ready=1 during and after reset.
- Throughput: 1 pixel/cycle with win_ready held high.
- Latency: a window is visible the cycle after its bottom-right pixel is accepted.
- Stall: while win_valid && !win_ready, the following are held stable and no pixel is accepted:
  - win_data, win_last, win_x and win_y
  - the counters, the line buffer, tl_q and bl_q
- Simultaneous win_ready and a new emitting accept: the old window is consumed and the new one loads in the same edge, with no bubble.
- A non-emitting accept in the same cycle as win_ready leaves win_valid=0 next cycle.
- sof_err is registered, asserts for exactly one cycle, and does not block acceptance.

## Test plan
- Basic frame: IMG_W=4, IMG_H=3, pixels 0..11 streamed with win_ready=1.
  - Exactly 6 windows are emitted.
  - First window: win_data=0x05040100, win_x=1, win_y=1.
  - Last window: win_data=0x0B0A0706, win_x=3, win_y=2, win_last=1. No other window has win_last=1.
- Back-pressure: same frame, win_ready toggled pseudo-randomly.
  - The identical 6-window sequence is produced.
  - win_data is stable while stalled, and in_ready=0 exactly when win_valid && !win_ready.
- Back-to-back frames: two frames 0..11 then 100..111 with no gap.
  - The second frame's first window is 0x69686564 (TL=100, TR=101, BL=104, BR=105).
  - No window straddles the two frames.
- SOF resync: assert in_sof on pixel 7 of a frame.
  - sof_err pulses one cycle later.
  - The counters restart, with the next window emitted at the bottom-right of the new row 1, col 1.
- Reset mid-frame: assert rst_n=0 for one cycle after pixel 6 while a window is held and win_ready=0.
  - All outputs read 0 after reset, with in_ready=1.
  - A fresh 0..11 frame reproduces the basic-frame results.
- Parameter sweep: IMG_W=2/IMG_H=2 yields exactly one window with win_last=1. IMG_W=64/IMG_H=2 yields 63 windows.

Source files
------------

// File: rtl/conv2x2_window_feeder.sv
// ---------------------------------------------------------------------------
// conv2x2_window_feeder
//
// Turns a raster pixel stream (one 8-bit pixel per beat) into the stream of
// every overlapping 2x2 window of the frame, feeding the 2x2 convolution
// stage. The previous image row lives in a single line buffer. Two small
// registers remember the previous top-right pixel (which becomes the next
// top-left) and the previous accepted pixel (which becomes the next
// bottom-left).
//
// Parameters
//   IMG_W, IMG_H : image size in pixels, each 2..64
//
// Ports
//   clk, rst_n  : clock (rising edge), synchronous active-low reset
//   in_valid    : source offers in_pixel
//   in_ready    : block takes the pixel this cycle
//   in_pixel    : unsigned 8-bit pixel
//   in_sof      : accepted pixel is the frame start (0,0)
//   win_valid   : win_* hold a window
//   win_ready   : downstream consumes the window this cycle
//   win_data    : [7:0]=TL, [15:8]=TR, [23:16]=BL, [31:24]=BR
//   win_last    : last window of the frame
//   win_x/win_y : column/row of the window's bottom-right pixel
//   sof_err     : one-cycle pulse, in_sof seen while not at (0,0)
// ---------------------------------------------------------------------------
module conv2x2_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    input  logic        in_sof,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [31:0] win_data,
    output logic        win_last,
    output logic [5:0]  win_x,
    output logic [5:0]  win_y,
    output logic        sof_err
);

    localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [5:0] X_LAST = 6'(IMG_W - 1);
    localparam logic [5:0] Y_LAST = 6'(IMG_H - 1);

    // Byte order of the packed window as the convolution stage expects it.
    typedef struct packed {
        logic [7:0] br;
        logic [7:0] bl;
        logic [7:0] tr;
        logic [7:0] tl;
    } win_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [5:0]    x_q, y_q;        // position of the next pixel to accept
    logic [7:0]    tl_q;            // previous TR -> this window's TL
    logic [7:0]    bl_q;            // previous accepted pixel -> this BL
    win_t          win_q;
    logic [7:0]    lb [0:IMG_W-1];  // previous row, indexed by column

    // -----------------------------------------------------------------------
    // Accept path
    // -----------------------------------------------------------------------
    logic          accept;
    logic [5:0]    px, py;          // position of the pixel being accepted
    logic [5:0]    nx, ny;          // counters after this accept
    logic [AW-1:0] lb_addr;
    logic [7:0]    tr;
    logic          emit;
    logic          sof_bad;

    // Single-entry output register: room exists when empty or draining now.
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // A frame-start pixel is forced to (0,0) whatever the counters say, so
    // a source that slipped or restarted re-aligns on its next SOF.
    always_comb begin
        px = x_q;
        py = y_q;
        if (in_sof) begin
            px = 6'd0;
            py = 6'd0;
        end
    end

    assign sof_bad = in_sof && ((x_q != 6'd0) || (y_q != 6'd0));

    always_comb begin
        nx = px + 6'd1;
        ny = py;
        if (px == X_LAST) begin
            nx = 6'd0;
            ny = (py == Y_LAST) ? 6'd0 : py + 6'd1;
        end
    end

    assign lb_addr = px[AW-1:0];
    assign tr      = lb[lb_addr];   // read-before-write: old row's pixel

    // Row 0 and column 0 only prime the buffers; no window ends there.
    assign emit = (px != 6'd0) && (py != 6'd0);

    // -----------------------------------------------------------------------
    // Line buffer: not reset. Row 0 rewrites every entry before row 1
    // reads it, so stale contents never reach a window.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && accept)
            lb[lb_addr] <= in_pixel;
    end

    // -----------------------------------------------------------------------
    // Counters, neighbour registers, output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            tl_q      <= '0;
            bl_q      <= '0;
            win_valid <= 1'b0;
            win_q     <= '0;
            win_last  <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= accept && sof_bad;

            if (accept) begin
                x_q  <= nx;
                y_q  <= ny;
                tl_q <= tr;
                bl_q <= in_pixel;
            end

            // A new window may load in the same edge the old one drains,
            // so back-to-back windows flow without a bubble.
            if (accept && emit) begin
                win_valid <= 1'b1;
                win_q     <= '{br: in_pixel, bl: bl_q, tr: tr, tl: tl_q};
                win_x     <= px;
                win_y     <= py;
                win_last  <= (px == X_LAST) && (py == Y_LAST);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    assign win_data = win_q;

endmodule

// File: tb/tb_conv2x2_window_feeder.sv
module tb_conv2x2_window_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  in_pixel  [3];
    logic        in_sof    [3];
    logic        win_valid [3];
    logic        win_ready [3];
    logic [31:0] win_data  [3];
    logic        win_last  [3];
    logic [5:0]  win_x     [3];
    logic [5:0]  win_y     [3];
    logic        sof_err   [3];

    conv2x2_window_feeder #(.IMG_W(4), .IMG_H(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pixel(in_pixel[0]), .in_sof(in_sof[0]),
        .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_data(win_data[0]),
        .win_last(win_last[0]), .win_x(win_x[0]), .win_y(win_y[0]), .sof_err(sof_err[0]));

    conv2x2_window_feeder #(.IMG_W(2), .IMG_H(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pixel(in_pixel[1]), .in_sof(in_sof[1]),
        .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_data(win_data[1]),
        .win_last(win_last[1]), .win_x(win_x[1]), .win_y(win_y[1]), .sof_err(sof_err[1]));

    conv2x2_window_feeder #(.IMG_W(64), .IMG_H(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_pixel(in_pixel[2]), .in_sof(in_sof[2]),
        .win_valid(win_valid[2]), .win_ready(win_ready[2]), .win_data(win_data[2]),
        .win_last(win_last[2]), .win_x(win_x[2]), .win_y(win_y[2]), .sof_err(sof_err[2]));

    typedef struct {
        logic [31:0] data;
        int          x;
        int          y;
        logic        last;
    } win_t;

    win_t exp_q[$];
    win_t obs_q[$];

    int errors = 0;
    int checks = 0;
    int sel = 0;
    bit mon_en = 1'b0;
    bit bp_mode = 1'b0;
    int cyc = 0;
    int sof_cnt = 0;
    int sof_cyc = -1;
    int acc_sof_cyc = -1;

    function automatic int w_of(input int d);
        case (d) 0: return 4; 1: return 2; default: return 64; endcase
    endfunction
    function automatic int h_of(input int d);
        case (d) 0: return 3; default: return 2; endcase
    endfunction

    // Reference model: the frame as a 2D image. Each window is read from
    // the image array around the pixel that completes it.
    int         mx, my;
    logic [7:0] img [64][64];

    task automatic model_push(input logic [7:0] p, input bit sof);
        int   w, h;
        win_t e;
        w = w_of(sel);
        h = h_of(sel);
        if (sof) begin mx = 0; my = 0; end
        img[my][mx] = p;
        if (mx >= 1 && my >= 1) begin
            e.data = {img[my][mx], img[my][mx-1], img[my-1][mx], img[my-1][mx-1]};
            e.x    = mx;
            e.y    = my;
            e.last = (mx == w-1) && (my == h-1);
            exp_q.push_back(e);
        end
        mx++;
        if (mx == w) begin
            mx = 0;
            my++;
            if (my == h) my = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard on every consumed window, handshake rule and
    // stall stability of the selected instance.
    initial begin : monitor
        logic        prev_stall;
        logic [31:0] pd;
        logic [5:0]  pxx, pyy;
        logic        pl;
        win_t        o, e;
        prev_stall = 1'b0;
        pd = '0; pxx = '0; pyy = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                checks++;
                if (in_ready[sel] !== (!win_valid[sel] || win_ready[sel])) begin
                    errors++;
                    $display("FAIL in_ready_rule: got %b valid=%b ready=%b cyc=%0d",
                             in_ready[sel], win_valid[sel], win_ready[sel], cyc);
                end
                if (prev_stall) begin
                    checks++;
                    if (win_valid[sel] !== 1'b1 || win_data[sel] !== pd || win_x[sel] !== pxx ||
                        win_y[sel] !== pyy || win_last[sel] !== pl) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h x=%0d y=%0d, want d=%h x=%0d y=%0d",
                                 win_valid[sel], win_data[sel], win_x[sel], win_y[sel], pd, pxx, pyy);
                    end
                end
                if (win_valid[sel] === 1'b1 && win_ready[sel] === 1'b1) begin
                    o.data = win_data[sel];
                    o.x    = int'(win_x[sel]);
                    o.y    = int'(win_y[sel]);
                    o.last = win_last[sel];
                    obs_q.push_back(o);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL window_extra: got d=%h x=%0d y=%0d, want none", o.data, o.x, o.y);
                    end else begin
                        e = exp_q.pop_front();
                        if (o.data !== e.data || o.x != e.x || o.y != e.y || o.last !== e.last) begin
                            errors++;
                            $display("FAIL window: got d=%h x=%0d y=%0d l=%b, want d=%h x=%0d y=%0d l=%b",
                                     o.data, o.x, o.y, o.last, e.data, e.x, e.y, e.last);
                        end
                    end
                end
                if (sof_err[sel] === 1'b1) begin
                    sof_cnt++;
                    sof_cyc = cyc;
                end
                prev_stall = win_valid[sel] && !win_ready[sel];
                pd  = win_data[sel];
                pxx = win_x[sel];
                pyy = win_y[sel];
                pl  = win_last[sel];
            end
        end
    end

    task automatic begin_test(input int d);
        sel = d;
        exp_q.delete();
        obs_q.delete();
        mx = 0;
        my = 0;
        sof_cnt = 0;
        sof_cyc = -1;
        acc_sof_cyc = -1;
    endtask

    // Stream n pixels (base+i, or random) with in_valid held high between
    // them; in_sof is set on pixel index sof_idx.
    task automatic stream(input int n, input int base, input int sof_idx, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            bit         s;
            bit         acc;
            int         waited;
            p = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
            s = (i == sof_idx);
            in_valid[sel] = 1'b1;
            in_pixel[sel] = p;
            in_sof[sel]   = s;
            acc    = 1'b0;
            waited = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (in_ready[sel] === 1'b1);
                if (acc) begin
                    model_push(p, s);
                    if (s) acc_sof_cyc = cyc;
                end
                @(posedge clk);
                #1;
                if (bp_mode) win_ready[sel] = 1'($urandom_range(0, 1));
                waited++;
                if (!acc && waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: pixel %0d not accepted in 200 cycles", i);
                    acc = 1'b1;
                end
            end
        end
        in_sof[sel] = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid[sel]  = 1'b0;
        in_sof[sel]    = 1'b0;
        win_ready[sel] = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (win_valid[d] !== 1'b0 || win_data[d] !== 32'h0 || win_last[d] !== 1'b0 ||
                win_x[d] !== 6'd0 || win_y[d] !== 6'd0 || sof_err[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b d=%h l=%b x=%0d y=%0d e=%b r=%b, want zeros r=1",
                         d, win_valid[d], win_data[d], win_last[d], win_x[d], win_y[d], sof_err[d], in_ready[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        int lc;
        begin_test(0);
        win_ready[0] = 1'b1;
        stream(12, 0, -1, 1'b0);
        idle(5);
        checks++;
        if (obs_q.size() != 6) begin
            errors++; $display("FAIL basic_count: got %0d, want 6", obs_q.size());
        end
        checks++;
        if (obs_q.size() < 1 || obs_q[0].data !== 32'h05040100 || obs_q[0].x != 1 || obs_q[0].y != 1) begin
            errors++; $display("FAIL basic_first: want d=05040100 x=1 y=1");
        end
        checks++;
        if (obs_q.size() < 6 || obs_q[5].data !== 32'h0B0A0706 || obs_q[5].x != 3 || obs_q[5].y != 2 ||
            obs_q[5].last !== 1'b1) begin
            errors++; $display("FAIL basic_last: want d=0B0A0706 x=3 y=2 last=1");
        end
        lc = 0;
        foreach (obs_q[i]) if (obs_q[i].last) lc++;
        checks++;
        if (lc != 1) begin errors++; $display("FAIL basic_last_count: got %0d, want 1", lc); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        begin_test(0);
        bp_mode = 1'b1;
        win_ready[0] = 1'b0;
        stream(12, 0, -1, 1'b0);
        bp_mode = 1'b0;
        idle(6);
        checks++;
        if (obs_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d, want 6", obs_q.size()); end
        checks++;
        if (obs_q.size() < 6 || obs_q[0].data !== 32'h05040100 || obs_q[5].data !== 32'h0B0A0706) begin
            errors++; $display("FAIL bp_sequence: want first 05040100 last 0B0A0706");
        end
        // Two random frames under back-pressure against the model.
        begin_test(0);
        bp_mode = 1'b1;
        stream(24, 0, -1, 1'b1);
        bp_mode = 1'b0;
        idle(6);
        checks++;
        if (obs_q.size() != 12 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_random_count: got %0d left %0d, want 12 left 0", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        begin_test(0);
        win_ready[0] = 1'b1;
        stream(12, 0, -1, 1'b0);
        stream(12, 100, 0, 1'b0);   // SOF on a real frame start: no error
        idle(5);
        checks++;
        if (obs_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d, want 12", obs_q.size()); end
        checks++;
        if (obs_q.size() < 12 || obs_q[6].data !== 32'h69686564 || obs_q[6].x != 1 || obs_q[6].y != 1 ||
            obs_q[5].last !== 1'b1 || obs_q[11].last !== 1'b1) begin
            errors++; $display("FAIL b2b_frame2: want window6 d=69686564 x=1 y=1, last on 5 and 11");
        end
        checks++;
        if (sof_cnt != 0) begin errors++; $display("FAIL b2b_sof_err: got %0d pulses, want 0", sof_cnt); end
    endtask

    task automatic test_sof_resync;
        begin_test(0);
        win_ready[0] = 1'b1;
        stream(19, 20, 7, 1'b0);
        idle(5);
        checks++;
        if (sof_cnt != 1 || sof_cyc != acc_sof_cyc + 1) begin
            errors++; $display("FAIL sof_err_pulse: got %0d pulses at cyc %0d, want 1 at %0d",
                               sof_cnt, sof_cyc, acc_sof_cyc + 1);
        end
        checks++;
        if (obs_q.size() != 8) begin errors++; $display("FAIL sof_count: got %0d, want 8", obs_q.size()); end
        checks++;
        if (obs_q.size() < 3 || obs_q[1].x != 2 || obs_q[1].y != 1 ||
            obs_q[2].data !== 32'h201F1C1B || obs_q[2].x != 1 || obs_q[2].y != 1) begin
            errors++; $display("FAIL sof_restart: want window2 d=201F1C1B x=1 y=1 after x=2 y=1");
        end
    endtask

    task automatic test_reset_midframe;
        int lc;
        begin_test(0);
        win_ready[0] = 1'b0;
        stream(6, 0, -1, 1'b0);
        in_valid[0] = 1'b1;
        in_pixel[0] = 8'd6;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready[0] !== 1'b0 || win_valid[0] !== 1'b1) begin
                errors++; $display("FAIL hold_stall: got ready=%b valid=%b, want 0 1", in_ready[0], win_valid[0]);
            end
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (win_valid[0] !== 1'b0 || win_data[0] !== 32'h0 || win_last[0] !== 1'b0 || win_x[0] !== 6'd0 ||
            win_y[0] !== 6'd0 || sof_err[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got v=%b d=%h x=%0d y=%0d r=%b, want zeros r=1",
                               win_valid[0], win_data[0], win_x[0], win_y[0], in_ready[0]);
        end
        begin_test(0);
        mon_en = 1'b1;
        win_ready[0] = 1'b1;
        stream(12, 0, -1, 1'b0);
        idle(5);
        checks++;
        if (obs_q.size() != 6 || obs_q[0].data !== 32'h05040100 || obs_q[5].data !== 32'h0B0A0706 ||
            obs_q[5].x != 3 || obs_q[5].y != 2) begin
            errors++; $display("FAIL midreset_frame: got %0d windows, want basic-frame sequence", obs_q.size());
        end
        lc = 0;
        foreach (obs_q[i]) if (obs_q[i].last) lc++;
        checks++;
        if (lc != 1) begin errors++; $display("FAIL midreset_last_count: got %0d, want 1", lc); end
    endtask

    task automatic test_sweep;
        int lc;
        begin_test(1);
        win_ready[1] = 1'b1;
        stream(4, 0, -1, 1'b1);
        idle(4);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].last !== 1'b1 || obs_q[0].x != 1 || obs_q[0].y != 1) begin
            errors++; $display("FAIL sweep_2x2: got %0d windows, want 1 with last=1", obs_q.size());
        end
        begin_test(2);
        bp_mode = 1'b1;
        stream(128, 0, -1, 1'b1);
        bp_mode = 1'b0;
        idle(6);
        checks++;
        if (obs_q.size() != 63) begin errors++; $display("FAIL sweep_64x2_count: got %0d, want 63", obs_q.size()); end
        lc = 0;
        foreach (obs_q[i]) if (obs_q[i].last) lc++;
        checks++;
        if (lc != 1 || obs_q.size() < 63 || obs_q[62].last !== 1'b1 || obs_q[62].x != 63 || obs_q[62].y != 1) begin
            errors++; $display("FAIL sweep_64x2_last: got %0d last flags, want 1 on x=63 y=1", lc);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sweep_missing: got %0d left, want 0", exp_q.size()); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_pixel[d]  = 8'd0;
            in_sof[d]    = 1'b0;
            win_ready[d] = 1'b1;
        end
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_sof_resync();
        test_reset_midframe();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
